// File: rtl/boolean_pkg.sv
// Shared definitions for the boolean ALU: opcode encoding, pin-field
// positions and the packed layout of the registered result byte.
package boolean_pkg;

    localparam int unsigned OPW_PIN = 4;

    // ui_in fields
    localparam int unsigned A_LSB = 0;
    localparam int unsigned A_MSB = 3;
    localparam int unsigned B_LSB = 4;
    localparam int unsigned B_MSB = 7;

    // uio_in fields
    localparam int unsigned OP_LSB  = 0;
    localparam int unsigned OP_MSB  = 2;
    localparam int unsigned INV_BIT = 3;
    localparam int unsigned IGN_LSB = 4;
    localparam int unsigned IGN_MSB = 7;

    // uo_out fields
    localparam int unsigned R_LSB = 0;
    localparam int unsigned R_MSB = 3;
    localparam int unsigned C_BIT = 4;
    localparam int unsigned Z_BIT = 5;
    localparam int unsigned P_BIT = 6;
    localparam int unsigned V_BIT = 7;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } opcode_t;

    // Bit order matches uo_out exactly, so the register drives the pins directly.
    typedef struct packed {
        logic               v;
        logic               p;
        logic               z;
        logic               c;
        logic [OPW_PIN-1:0] r;
    } status_t;

    function automatic logic is_arith(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/boolean_if.sv
// Pin bundle of the boolean block: enable, operand/opcode inputs and the
// three output bytes.
interface boolean_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/boolean_alu.sv
// Purely combinational operation unit: bitwise/arithmetic op, optional
// result inversion, carry/borrow, zero and parity flags.
module boolean_alu
    import boolean_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  opcode_t        op,
    input  logic           inv,
    output logic [OPW-1:0] r,
    output logic           c,
    output logic           z,
    output logic           p
);

    logic [OPW-1:0] and_bits;
    logic [OPW-1:0] or_bits;
    logic [OPW-1:0] xor_bits;
    logic [OPW:0]   sum;
    logic [OPW:0]   diff;
    logic [OPW-1:0] raw;
    logic           carry;

    generate
        for (genvar gi = 0; gi < OPW; gi++) begin : g_bit
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // The extra MSB of the widened difference is set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        case (op)
            OP_AND:  raw = and_bits;
            OP_OR:   raw = or_bits;
            OP_XOR:  raw = xor_bits;
            OP_NAND: raw = ~and_bits;
            OP_NOR:  raw = ~or_bits;
            OP_XNOR: raw = ~xor_bits;
            OP_ADD:  raw = sum[OPW-1:0];
            OP_SUB:  raw = diff[OPW-1:0];
            default: raw = '0;
        endcase
        if (is_arith(op)) begin
            carry = (op == OP_ADD) ? sum[OPW] : diff[OPW];
        end
    end

    // Inversion applies to R only; the flags below follow the final R.
    assign r = inv ? ~raw : raw;
    assign c = carry;
    assign z = (r == '0);
    assign p = ^r;

endmodule

// File: rtl/boolean.sv
// Registered 4-bit boolean/arithmetic unit on an 8-bit pin map; the
// output byte comes straight from a register with a sticky valid bit.
module boolean
    import boolean_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    boolean_if.slave      bus
);

    logic [OPW-1:0] alu_r;
    logic           alu_c;
    logic           alu_z;
    logic           alu_p;
    status_t        status_reg;
    status_t        status_next;
    logic           unused_uio;

    boolean_alu #(
        .OPW (OPW)
    ) u_alu (
        .a   (bus.ui_in[A_MSB:A_LSB]),
        .b   (bus.ui_in[B_MSB:B_LSB]),
        .op  (opcode_t'(bus.uio_in[OP_MSB:OP_LSB])),
        .inv (bus.uio_in[INV_BIT]),
        .r   (alu_r),
        .c   (alu_c),
        .z   (alu_z),
        .p   (alu_p)
    );

    always_comb begin
        status_next   = status_reg;
        if (bus.ena) begin
            status_next.r = alu_r;
            status_next.c = alu_c;
            status_next.z = alu_z;
            status_next.p = alu_p;
            status_next.v = 1'b1;
        end
    end

    // rst_n is active-high despite its name; the port name is fixed by the harness.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

    assign bus.uo_out  = status_reg;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    assign unused_uio = ^bus.uio_in[IGN_MSB:IGN_LSB];

endmodule

// File: tb/tb_boolean.sv
// Directed bench for the boolean block: vector table plus reset, hold and
// asynchronous-reset sequences.
module tb_boolean;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    boolean_if bus ();

    boolean #(.OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       inv;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end else begin
            $display("ok   %s value=%02h", name, act);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic inv);
        logic [3:0] junk;
        junk       = 4'($urandom_range(0, 15));
        bus.ui_in  = {b, a};
        bus.uio_in = {junk, inv, op};
    endtask

    vec_t vecs[22];

    initial begin
        checks = 0;
        errors = 0;

        //           a      b     op   inv  exp {V,P,Z,C,R}
        vecs[0]  = '{4'd9,  4'd8,  3'd6, 1'b0, 8'hD1};
        vecs[1]  = '{4'd15, 4'd15, 3'd6, 1'b0, 8'hDE};
        vecs[2]  = '{4'd3,  4'd5,  3'd7, 1'b0, 8'hDE};
        vecs[3]  = '{4'd7,  4'd7,  3'd7, 1'b0, 8'hA0};
        vecs[4]  = '{4'd0,  4'd1,  3'd7, 1'b0, 8'h9F};
        vecs[5]  = '{4'hC,  4'hA,  3'd0, 1'b0, 8'hC8};
        vecs[6]  = '{4'hC,  4'hA,  3'd1, 1'b0, 8'hCE};
        vecs[7]  = '{4'hC,  4'hA,  3'd2, 1'b0, 8'h86};
        vecs[8]  = '{4'hC,  4'hA,  3'd3, 1'b0, 8'hC7};
        vecs[9]  = '{4'hC,  4'hA,  3'd4, 1'b0, 8'hC1};
        vecs[10] = '{4'hC,  4'hA,  3'd5, 1'b0, 8'h89};
        vecs[11] = '{4'hC,  4'hA,  3'd0, 1'b1, 8'hC7};
        vecs[12] = '{4'hC,  4'hA,  3'd1, 1'b1, 8'hC1};
        vecs[13] = '{4'hC,  4'hA,  3'd2, 1'b1, 8'h89};
        vecs[14] = '{4'hC,  4'hA,  3'd3, 1'b1, 8'hC8};
        vecs[15] = '{4'hC,  4'hA,  3'd4, 1'b1, 8'hCE};
        vecs[16] = '{4'hC,  4'hA,  3'd5, 1'b1, 8'h86};
        vecs[17] = '{4'd9,  4'd8,  3'd6, 1'b1, 8'hDE};
        vecs[18] = '{4'd7,  4'd7,  3'd7, 1'b1, 8'h8F};
        vecs[19] = '{4'd15, 4'd1,  3'd6, 1'b0, 8'hB0};
        vecs[20] = '{4'd5,  4'd3,  3'd7, 1'b0, 8'hC2};
        vecs[21] = '{4'd0,  4'd0,  3'd6, 1'b1, 8'h8F};

        // Reset with random inputs and ena high
        rst_n   = 1'b1;
        bus.ena = 1'b1;
        bus.ui_in  = 8'($urandom());
        bus.uio_in = 8'($urandom());
        repeat (3) begin
            @(negedge clk);
            bus.ui_in  = 8'($urandom());
            bus.uio_in = 8'($urandom());
        end
        check("reset_uo_out", bus.uo_out, 8'h00);
        check("reset_uio_oe", bus.uio_oe, 8'h00);
        check("reset_uio_out", bus.uio_out, 8'h00);

        // Release; a disabled edge must not set V
        rst_n   = 1'b0;
        bus.ena = 1'b0;
        @(negedge clk);
        check("no_valid_while_disabled", bus.uo_out, 8'h00);

        // Vector table, one new operation per cycle
        bus.ena = 1'b1;
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].inv);
            @(negedge clk);
            $display("vec %0d a=%h b=%h op=%0d inv=%b", i, vecs[i].a, vecs[i].b,
                     vecs[i].op, vecs[i].inv);
            check($sformatf("vec%0d", i), bus.uo_out, vecs[i].exp);
        end
        check("uio_out_running", bus.uio_out, 8'h00);
        check("uio_oe_running", bus.uio_oe, 8'h00);

        // Hold: establish AND result, then ena=0 with churning inputs
        drive(4'hC, 4'hA, 3'd0, 1'b0);
        @(negedge clk);
        check("hold_setup", bus.uo_out, 8'hC8);
        bus.ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'(i + 3), 4'(7 - i), 3'(i + 2), i[0]);
            @(negedge clk);
            check($sformatf("hold%0d", i), bus.uo_out, 8'hC8);
        end
        bus.ena = 1'b1;
        drive(4'hC, 4'hA, 3'd2, 1'b0);
        @(negedge clk);
        check("hold_resume", bus.uo_out, 8'h86);

        // Async reset between edges discards the in-flight ADD
        drive(4'd9, 4'd8, 3'd6, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_reset_immediate", bus.uo_out, 8'h00);
        @(negedge clk);
        check("async_reset_discard", bus.uo_out, 8'h00);
        rst_n   = 1'b0;
        bus.ena = 1'b0;
        @(negedge clk);
        check("post_reset_disabled", bus.uo_out, 8'h00);
        bus.ena = 1'b1;
        drive(4'd3, 4'd5, 3'd7, 1'b0);
        @(negedge clk);
        check("post_reset_first", bus.uo_out, 8'hDE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boolean.md
BOOLEAN -- requirements
Module: boolean

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter: OPW, default 4, operand width in bits; only the value 4 SHALL be supported at the 8-bit pin map.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-high (1 = in reset); port name kept for harness compatibility.
REQ-005 ena  input  1  1 = update registers; 0 = hold all registers.
REQ-006 ui_in  input  8  [3:0] = operand A, [7:4] = operand B.
REQ-007 uio_in  input  8  [2:0] = opcode; [3] = invert-result flag; [7:4] ignored.
REQ-008 uo_out  output  8  [3:0] = result R, [4] = carry/borrow C, [5] = zero Z, [6] = parity P, [7] = valid V.
REQ-009 uio_out  output  8  SHALL be constant 8'h00.
REQ-010 uio_oe  output  8  SHALL be constant 8'h00 (all bidirectional pins are inputs).

Function
REQ-011 Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ADD (A+B), 7 SUB (A-B); all bitwise ops act on 4 bits.
REQ-012 ADD: R = (A+B) mod 16; C = bit 4 of the 5-bit sum.
REQ-013 SUB: R = (A-B) mod 16 (two's complement); C = 1 when A < B unsigned (borrow), else 0.
REQ-014 Logic opcodes (0-5): C = 0.
REQ-015 Invert flag uio_in[3] = 1: R is bitwise-inverted after the operation; C is not affected.
REQ-016 Z = 1 when the final 4-bit R = 0; P = XOR-reduction of the final R (odd parity = 1).
REQ-017 Latency: inputs sampled on the rising clk edge with ena = 1; uo_out reflects them one cycle later; uo_out is driven from registers only, with no combinational input-to-output path.
REQ-018 V SHALL be 0 from reset until the first edge with ena = 1, then 1 permanently until the next reset.
REQ-019 ena = 0: R, C, Z, P and V hold their last values; input changes are ignored.
REQ-020 Boundaries: ADD 15+15 -> R = 14, C = 1; SUB 0-1 -> R = 15, C = 1; SUB A = B -> R = 0, C = 0, Z = 1.
REQ-021 No handshake; a new operation is accepted every enabled cycle (throughput 1/cycle).

Reset
REQ-022 While rst_n = 1, uo_out SHALL be 8'h00 immediately, independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight result; the first enabled edge after release produces V = 1 with that edge's inputs.
REQ-024 uio_out and uio_oe SHALL be 0 in and out of reset.

Structure
REQ-025 A shared package SHALL hold the 3-bit opcode enumeration (OP_AND..OP_SUB) and the pin-field index constants.
REQ-026 One sub-module, boolean_alu, SHALL hold the purely combinational operation, invert, carry and flag logic; the top SHALL hold the output register, V flag and pin mapping.
REQ-027 Unused inputs (uio_in[7:4]) SHALL be explicitly sunk to avoid lint warnings.

Verification
REQ-028 Reset: rst_n = 1 with random inputs -> uo_out = 8'h00, uio_oe = 8'h00, uio_out = 8'h00; release, one enabled edge -> V = 1.
REQ-029 ADD: A = 9, B = 8, op = 6, inv = 0 -> after 1 cycle R = 1, C = 1, Z = 0, P = 1, uo_out = 8'hD1.
REQ-030 SUB borrow and zero: A = 3, B = 5, op = 7 -> R = 14, C = 1; then A = B = 7 -> R = 0, C = 0, Z = 1.
REQ-031 Logic sweep: A = 4'hC, B = 4'hA, opcodes 0-5 -> R = 8, E, 6, 7, 1, 9 respectively, C = 0; repeat with inv = 1 -> R bitwise-inverted.
REQ-032 Hold: establish a result, drive ena = 0, change all inputs for 5 cycles -> uo_out unchanged; ena = 1 -> new result after one edge.
REQ-033 Async reset mid-stream: assert rst_n between clock edges -> uo_out = 0 immediately, without waiting for a clock edge.
